// File: rtl/alu_issue_ctrl.sv
// Issue controller: one op/cycle to ALU or iterative mul/div, issue 1 cycle after accept, mul/div wb MD_LATENCY after md_go.
// Backpressure: in_ready drops on mul/div structural, RAW, WAW and write-port collision hazards.
module alu_issue_ctrl #(
  parameter int MD_LATENCY = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [9:0] in_opcode,
  input  logic [6:0] in_funct7,
  input  logic [4:0] in_rs1,
  input  logic [4:0] in_rs2,
  input  logic [4:0] in_rd,
  input  logic       in_uses_rs2,
  output logic       alu_go,
  output logic [9:0] alu_opcode,
  output logic [6:0] alu_funct7,
  output logic [4:0] alu_rs1,
  output logic [4:0] alu_rs2,
  output logic [4:0] alu_rd,
  output logic       md_go,
  output logic       wb_en,
  output logic       wb_sel,
  output logic [4:0] wb_rd,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_MD_BUSY, S_MD_WB} state_t;

  // Counter starts at MD_LATENCY in the md_go cycle so it reads 1 in the cycle before writeback.
  localparam logic [5:0] LP_CNT_INIT = 6'(MD_LATENCY);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [5:0] r_cnt;
  logic [4:0] r_md_rd;
  logic       r_alu_go;
  logic       r_md_go;
  logic [9:0] r_alu_opcode;
  logic [6:0] r_alu_funct7;
  logic [4:0] r_alu_rs1;
  logic [4:0] r_alu_rs2;
  logic [4:0] r_alu_rd;

  logic w_long;
  logic w_raw;
  logic w_waw;
  logic w_stall;
  logic w_accept;

  assign w_long = ((in_opcode[6:0] == 7'h33) || (in_opcode[6:0] == 7'h3b)) &&
                  (in_funct7 == 7'b0000001);
  assign w_raw  = (r_md_rd != 5'd0) &&
                  ((in_rs1 == r_md_rd) || (in_uses_rs2 && (in_rs2 == r_md_rd)));
  assign w_waw  = (in_rd != 5'd0) && (in_rd == r_md_rd);
  assign w_stall = (r_state == S_MD_BUSY) &&
                   (w_long || w_raw || w_waw || (r_cnt == 6'd1));
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_accept && w_long) w_state_nxt = S_MD_BUSY;
      S_MD_BUSY: if (r_cnt == 6'd1) w_state_nxt = S_MD_WB;
      S_MD_WB:   w_state_nxt = (w_accept && w_long) ? S_MD_BUSY : S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = !reset && !w_stall;
    busy     = (r_state != S_IDLE);
    wb_sel   = (r_state == S_MD_WB);
    wb_rd    = (r_state == S_MD_WB) ? r_md_rd : r_alu_rd;
    wb_en    = ((r_state == S_MD_WB) && (r_md_rd != 5'd0)) ||
               (r_alu_go && (r_alu_rd != 5'd0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= 6'd0;
      r_md_rd      <= 5'd0;
      r_alu_go     <= 1'b0;
      r_md_go      <= 1'b0;
      r_alu_opcode <= 10'd0;
      r_alu_funct7 <= 7'd0;
      r_alu_rs1    <= 5'd0;
      r_alu_rs2    <= 5'd0;
      r_alu_rd     <= 5'd0;
    end else begin
      r_alu_go <= w_accept && !w_long;
      r_md_go  <= w_accept && w_long;
      if (w_accept) begin
        r_alu_opcode <= in_opcode;
        r_alu_funct7 <= in_funct7;
        r_alu_rs1    <= in_rs1;
        r_alu_rs2    <= in_rs2;
        r_alu_rd     <= in_rd;
      end
      if (w_accept && w_long) begin
        r_md_rd <= in_rd;
        r_cnt   <= LP_CNT_INIT;
      end else if (r_state == S_MD_BUSY) begin
        r_cnt <= r_cnt - 6'd1;
      end
    end
  end

  assign alu_go     = r_alu_go;
  assign md_go      = r_md_go;
  assign alu_opcode = r_alu_opcode;
  assign alu_funct7 = r_alu_funct7;
  assign alu_rs1    = r_alu_rs1;
  assign alu_rs2    = r_alu_rs2;
  assign alu_rd     = r_alu_rd;

  a_wb_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(r_alu_go && (r_state == S_MD_WB)));

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: short/long issue, RAW/WAW/structural/collision stalls, reset mid-op.
module tb_alu_issue_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_opcode;
  logic [6:0] in_funct7;
  logic [4:0] in_rs1, in_rs2, in_rd;
  logic       in_uses_rs2;
  logic       alu_go;
  logic [9:0] alu_opcode;
  logic [6:0] alu_funct7;
  logic [4:0] alu_rs1, alu_rs2, alu_rd;
  logic       md_go, wb_en, wb_sel, busy;
  logic [4:0] wb_rd;

  int n_tests = 0;
  int n_fail  = 0;

  alu_issue_ctrl #(.MD_LATENCY(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct7(in_funct7),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_uses_rs2(in_uses_rs2),
    .alu_go(alu_go), .alu_opcode(alu_opcode), .alu_funct7(alu_funct7),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_rd(alu_rd),
    .md_go(md_go), .wb_en(wb_en), .wb_sel(wb_sel), .wb_rd(wb_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start of a cycle: just after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Sample point: falling edge, inputs settled.
  task automatic smp();
    #4;
  endtask

  task automatic drv(input logic v, input logic [9:0] op, input logic [6:0] f7,
                     input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                     input logic u2);
    in_valid    = v;
    in_opcode   = op;
    in_funct7   = f7;
    in_rs1      = r1;
    in_rs2      = r2;
    in_rd       = rd;
    in_uses_rs2 = u2;
  endtask

  task automatic idle();
    drv(1'b0, 10'h000, 7'h00, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    cyc(); cyc(); smp();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_alu_go", alu_go, 0);
    chk("rst_md_go", md_go, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_wb_sel", wb_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_opcode", alu_opcode, 0);
    chk("rst_alu_rd", alu_rd, 0);

    // Short op: addi x5, x1
    cyc(); reset = 1'b0;
    drv(1'b1, 10'h013, 7'h00, 5'd1, 5'd0, 5'd5, 1'b0); smp();
    chk("short_ready", in_ready, 1);
    cyc(); idle(); smp();
    chk("short_alu_go", alu_go, 1);
    chk("short_md_go", md_go, 0);
    chk("short_wb_en", wb_en, 1);
    chk("short_wb_sel", wb_sel, 0);
    chk("short_wb_rd", wb_rd, 5);
    chk("short_alu_opcode", alu_opcode, 10'h013);
    chk("short_busy", busy, 0);
    cyc(); smp();
    chk("short_c2_alu_go", alu_go, 0);
    chk("short_c2_wb_en", wb_en, 0);

    // Long op mul x7,x1,x2 then RAW add x8,x7,x1
    cyc(); drv(1'b1, 10'h033, 7'h01, 5'd1, 5'd2, 5'd7, 1'b1); smp();
    chk("mul_ready", in_ready, 1);
    cyc(); drv(1'b1, 10'h033, 7'h00, 5'd7, 5'd1, 5'd8, 1'b1); smp();
    chk("mul_md_go", md_go, 1);
    chk("mul_alu_go", alu_go, 0);
    chk("mul_busy_c1", busy, 1);
    chk("mul_alu_rd", alu_rd, 7);
    chk("mul_wb_en_c1", wb_en, 0);
    chk("raw_stall_c1", in_ready, 0);
    for (int c = 2; c <= 8; c++) begin
      cyc(); smp();
      chk("raw_stall", in_ready, 0);
      chk("mul_busy", busy, 1);
      chk("mul_no_wb", wb_en, 0);
      chk("mul_md_go_low", md_go, 0);
    end
    cyc(); smp();
    chk("mul_wb_en", wb_en, 1);
    chk("mul_wb_sel", wb_sel, 1);
    chk("mul_wb_rd", wb_rd, 7);
    chk("mul_busy_c9", busy, 1);
    chk("raw_accept_c9", in_ready, 1);
    cyc(); idle(); smp();
    chk("raw_alu_go_c10", alu_go, 1);
    chk("raw_alu_rd", alu_rd, 8);
    chk("raw_wb_rd", wb_rd, 8);
    chk("raw_wb_sel", wb_sel, 0);
    chk("idle_busy_c10", busy, 0);

    // mul x0 then add x8,x0,x0: x0 never a hazard, never written
    cyc(); drv(1'b1, 10'h033, 7'h01, 5'd1, 5'd2, 5'd0, 1'b1); smp();
    chk("mulx0_ready", in_ready, 1);
    cyc(); drv(1'b1, 10'h033, 7'h00, 5'd0, 5'd0, 5'd8, 1'b1); smp();
    chk("x0_no_stall", in_ready, 1);
    chk("mulx0_md_go", md_go, 1);
    cyc(); idle(); smp();
    chk("x0_alu_go", alu_go, 1);
    chk("x0_busy", busy, 1);
    chk("x0_wb_rd", wb_rd, 8);
    for (int c = 3; c <= 8; c++) begin
      cyc(); smp();
      chk("mulx0_no_wb", wb_en, 0);
    end
    cyc(); smp();
    chk("mulx0_busy_c9", busy, 1);
    chk("mulx0_wb_en_c9", wb_en, 0);
    cyc(); smp();
    chk("mulx0_busy_c10", busy, 0);

    // Independent op during mul, then write-port collision slot
    cyc(); drv(1'b1, 10'h033, 7'h01, 5'd1, 5'd2, 5'd7, 1'b1); smp();
    cyc(); drv(1'b1, 10'h033, 7'h00, 5'd1, 5'd2, 5'd9, 1'b1); smp();
    chk("indep_ready", in_ready, 1);
    cyc(); idle(); smp();
    chk("indep_alu_go", alu_go, 1);
    chk("indep_busy", busy, 1);
    chk("indep_wb_rd", wb_rd, 9);
    chk("indep_wb_sel", wb_sel, 0);
    for (int c = 3; c <= 7; c++) begin
      cyc(); smp();
      chk("indep_busy_hold", busy, 1);
    end
    cyc(); drv(1'b1, 10'h033, 7'h00, 5'd3, 5'd4, 5'd10, 1'b1); smp();
    chk("collide_stall_c8", in_ready, 0);
    cyc(); smp();
    chk("collide_accept_c9", in_ready, 1);
    chk("collide_wb_sel", wb_sel, 1);
    chk("collide_wb_rd", wb_rd, 7);
    cyc(); idle(); smp();
    chk("collide_alu_go_c10", alu_go, 1);
    chk("collide_alu_rd", alu_rd, 10);
    chk("collide_wb_sel_c10", wb_sel, 0);
    chk("collide_busy_c10", busy, 0);

    // Structural: mul then div x11; then WAW short op on x11
    cyc(); drv(1'b1, 10'h033, 7'h01, 5'd1, 5'd2, 5'd7, 1'b1); smp();
    cyc(); drv(1'b1, 10'h233, 7'h01, 5'd1, 5'd2, 5'd11, 1'b1); smp();
    chk("struct_stall_c1", in_ready, 0);
    for (int c = 2; c <= 8; c++) begin
      cyc(); smp();
      chk("struct_stall", in_ready, 0);
    end
    cyc(); smp();
    chk("struct_accept_c9", in_ready, 1);
    chk("struct_wb_rd_c9", wb_rd, 7);
    cyc(); drv(1'b1, 10'h013, 7'h00, 5'd1, 5'd0, 5'd11, 1'b0); smp();
    chk("div_md_go_c10", md_go, 1);
    chk("div_alu_go_c10", alu_go, 0);
    chk("div_alu_opcode", alu_opcode, 10'h233);
    chk("div_alu_rd", alu_rd, 11);
    chk("div_busy", busy, 1);
    chk("waw_stall_c10", in_ready, 0);
    for (int c = 11; c <= 17; c++) begin
      cyc(); smp();
      chk("waw_stall", in_ready, 0);
    end
    cyc(); smp();
    chk("div_wb_en", wb_en, 1);
    chk("div_wb_sel", wb_sel, 1);
    chk("div_wb_rd", wb_rd, 11);
    chk("waw_accept_c18", in_ready, 1);
    cyc(); idle(); smp();
    chk("waw_alu_go", alu_go, 1);
    chk("waw_alu_rd", alu_rd, 11);
    chk("waw_busy", busy, 0);

    // Reset mid-op: mulw x12 dropped
    cyc(); drv(1'b1, 10'h03b, 7'h01, 5'd1, 5'd2, 5'd12, 1'b1); smp();
    chk("mulw_ready", in_ready, 1);
    cyc(); idle(); smp();
    chk("mulw_md_go", md_go, 1);
    chk("mulw_busy", busy, 1);
    cyc(); cyc();
    cyc(); reset = 1'b1; smp();
    chk("rstmid_in_ready", in_ready, 0);
    chk("rstmid_busy_c4", busy, 1);
    cyc(); reset = 1'b0; smp();
    chk("rstmid_busy_c5", busy, 0);
    chk("rstmid_ready_c5", in_ready, 1);
    chk("rstmid_md_go_c5", md_go, 0);
    for (int c = 6; c <= 10; c++) begin
      cyc(); smp();
      chk("rstmid_no_wb", wb_en, 0);
      chk("rstmid_no_busy", busy, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
